// File: rtl/if_dp_queue_if.sv
// Fetch-to-dispatch handshake bundle for the instruction queue.
// master = fetch/dispatch side, slave = the queue itself.
interface if_dp_queue_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_PC;
    logic [XLEN-1:0] if_NPC;
    logic            if_pred_taken;
    logic            if_ready;

    logic            dp_stall;
    logic            dp_valid;
    logic [XLEN-1:0] dp_inst;
    logic [XLEN-1:0] dp_PC;
    logic [XLEN-1:0] dp_NPC;
    logic            dp_pred_taken;

    modport master (
        output if_valid, if_inst, if_PC, if_NPC, if_pred_taken, dp_stall,
        input  if_ready, dp_valid, dp_inst, dp_PC, dp_NPC, dp_pred_taken
    );

    modport slave (
        input  if_valid, if_inst, if_PC, if_NPC, if_pred_taken, dp_stall,
        output if_ready, dp_valid, dp_inst, dp_PC, dp_NPC, dp_pred_taken
    );
endinterface

// File: rtl/if_dp_queue.sv
// Circular instruction queue between fetch and dispatch; squash drops every entry.
// Optional IFQ_BYPASS_EN: an empty queue forwards fetch straight to dispatch.
module if_dp_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    if_dp_queue_if.slave           q,
    output logic [$clog2(DEPTH):0] count
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [DEPTH-1:0] ent_valid;
    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [XLEN-1:0] mem_npc  [DEPTH];
    logic [DEPTH-1:0] mem_pt;

    logic            full;
    logic            head_valid;
    logic            byp;
    logic            enq;
    logic            deq;
    logic [PW:0]     count_nxt;

    assign full       = (count == FULL_CNT);
    assign head_valid = ent_valid[head];

`ifdef IFQ_BYPASS_EN
    assign byp = (count == '0) & q.if_valid & ~squash;
`else
    assign byp = 1'b0;
`endif

    // A bypassed instruction taken by dispatch this cycle never lands in the array.
    assign enq = q.if_valid & ~full & ~squash & ~(byp & ~q.dp_stall);
    assign deq = head_valid & ~q.dp_stall & ~squash;

    assign q.if_ready = ~full;

    always_comb begin
        count_nxt = count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    end

    always_comb begin
        q.dp_valid      = 1'b0;
        q.dp_inst       = NOP;
        q.dp_PC         = '0;
        q.dp_NPC        = '0;
        q.dp_pred_taken = 1'b0;
        if (head_valid) begin
            q.dp_valid      = 1'b1;
            q.dp_inst       = mem_inst[head];
            q.dp_PC         = mem_pc[head];
            q.dp_NPC        = mem_npc[head];
            q.dp_pred_taken = mem_pt[head];
        end else if (byp) begin
            q.dp_valid      = 1'b1;
            q.dp_inst       = q.if_inst;
            q.dp_PC         = q.if_PC;
            q.dp_NPC        = q.if_NPC;
            q.dp_pred_taken = q.if_pred_taken;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else if (squash) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            // head==tail only when empty or full, so enq and deq never hit the same slot
            if (enq) begin
                tail            <= tail + 1'b1;
                ent_valid[tail] <= 1'b1;
            end
            if (deq) begin
                head            <= head + 1'b1;
                ent_valid[head] <= 1'b0;
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem_inst[tail] <= q.if_inst;
            mem_pc[tail]   <= q.if_PC;
            mem_npc[tail]  <= q.if_NPC;
            mem_pt[tail]   <= q.if_pred_taken;
        end
    end

    a_count_max: assert property (@(posedge clock) disable iff (!reset)
        count <= FULL_CNT);
    a_no_enq_full: assert property (@(posedge clock) disable iff (!reset)
        !(enq && full));
    a_no_deq_empty: assert property (@(posedge clock) disable iff (!reset)
        !(deq && count == '0));
endmodule

// File: tb/tb_if_dp_queue.sv
// Directed bench for if_dp_queue: reset, fill, drain/wrap, squash, simultaneous, bypass.
// Follows IFQ_BYPASS_EN to pick the matching expectations.
module tb_if_dp_queue;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic       clock;
    logic       reset;
    logic       squash;
    logic [2:0] count;

    int vec_cnt = 0;
    int err_cnt = 0;

    if_dp_queue_if #(.XLEN(32)) bus ();

    if_dp_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .squash(squash),
        .q     (bus.slave),
        .count (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic sq);
        bus.if_valid      = v;
        bus.if_inst       = inst_of(pc);
        bus.if_PC         = pc;
        bus.if_NPC        = pc + 32'd4;
        bus.if_pred_taken = pc[2];
        bus.dp_stall      = st;
        squash            = sq;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] mq[$];
    int          idx;
    int          ndisp;
    logic        st;
    logic        v;
    logic [31:0] pc;
    logic        enq_m;
    logic        deq_m;

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        // reset state
        chk("rst_count", count, 3'd0);
        chk("rst_dpv", bus.dp_valid, 1'b0);
        chk("rst_inst", bus.dp_inst, NOP);
        chk("rst_pc", bus.dp_PC, 32'h0);
        chk("rst_rdy", bus.if_ready, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: async reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h40 + 32'(i) * 4, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1_count3", count, 3'd3);
        #1 reset = 1'b0;
        #1;
        chk("t1_count", count, 3'd0);
        chk("t1_dpv", bus.dp_valid, 1'b0);
        chk("t1_inst", bus.dp_inst, NOP);
        chk("t1_rdy", bus.if_ready, 1'b1);
        tick();
        reset = 1'b1;
        tick();

        // 2: fill under stall, overflow attempt, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i) * 4, 1'b1, 1'b0);
            tick();
            chk("t2_hold_pc", bus.dp_PC, 32'h0);
        end
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        chk("t2_count", count, 3'd4);
        chk("t2_rdy", bus.if_ready, 1'b0);
        tick();
        chk("t2_ovf_count", count, 3'd4);
        chk("t2_ovf_pc", bus.dp_PC, 32'h0);
        chk("t2_head_inst", bus.dp_inst, 32'hA5A5_0000);
        chk("t2_head_npc", bus.dp_NPC, 32'h4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            chk("t2_drain_pc", bus.dp_PC, 32'(i) * 4);
            chk("t2_drain_pt", bus.dp_pred_taken, (i % 2) == 1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_empty", count, 3'd0);
        chk("t2_empty_inst", bus.dp_inst, NOP);

        // 3: 10 instructions with toggling stall, model-checked order
        mq.delete();
        idx   = 0;
        ndisp = 0;
        st    = 1'b1;
        for (int cyc = 0; cyc < 60 && ndisp < 10; cyc++) begin
            v  = (idx < 10);
            pc = 32'h100 + 32'(idx) * 4;
            drive(v, pc, st, 1'b0);
            chk("t3_rdy", bus.if_ready, mq.size() < 4);
            if (mq.size() > 0) begin
                chk("t3_dpv", bus.dp_valid, 1'b1);
                chk("t3_pc", bus.dp_PC, mq[0]);
                chk("t3_inst", bus.dp_inst, inst_of(mq[0]));
            end else begin
                chk("t3_dpv", bus.dp_valid, BYP && v);
            end
            enq_m = v && (mq.size() < 4);
            deq_m = (mq.size() > 0) && !st;
            if (deq_m) begin
                void'(mq.pop_front());
                ndisp++;
            end
            if (enq_m) begin
                mq.push_back(pc);
                idx++;
            end
            tick();
            st = ~st;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_ndisp", 64'(ndisp), 64'd10);
        chk("t3_count", count, 3'd0);
        chk("t3_dpv_end", bus.dp_valid, 1'b0);

        // 4: squash with same-cycle enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h80 + 32'(i) * 4, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'h8C, 1'b0, 1'b1);
        chk("t4_count3", count, 3'd3);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t4_count", count, 3'd0);
        chk("t4_dpv", bus.dp_valid, 1'b0);
        chk("t4_inst", bus.dp_inst, NOP);
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_new_pc", bus.dp_PC, 32'h200);
        chk("t4_new_count", count, 3'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t4_empty", count, 3'd0);

        // 5: simultaneous enqueue/dequeue at count=2
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h404, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h408 + 32'(i) * 4, 1'b0, 1'b0);
            chk("t5_pc", bus.dp_PC, 32'h400 + 32'(i) * 4);
            tick();
            chk("t5_count", count, 3'd2);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            chk("t5_drain_pc", bus.dp_PC, 32'h40C + 32'(i) * 4);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5_empty", count, 3'd0);

        // 6: empty-queue fetch with and without dispatch stall
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        chk("t6_dpv", bus.dp_valid, BYP);
        chk("t6_pc", bus.dp_PC, BYP ? 32'h300 : 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6_count", count, BYP ? 3'd0 : 3'd1);
        chk("t6_dpv_next", bus.dp_valid, !BYP);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        chk("t6s_dpv", bus.dp_valid, BYP);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6s_count", count, 3'd1);
        chk("t6s_pc", bus.dp_PC, 32'h300);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("t6_end", count, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
